// File: rtl/decode_stage_controller_pkg.sv
// HighLevelControl: shared control-path types for the decode stage.
//   immSrc      - immediate-format selector consumed by the immediate extender
//   OPC_*       - base-ISA major opcodes recognised by the decode stage
//   decodeInfo  - per-instruction classification stored alongside each entry
//   decodeState - decode sequencer states (RUN accepts, HALT blocks intake)
package HighLevelControl;

  typedef enum logic [1:0] {
    Imm11t0 = 2'd0,
    Imm4t0  = 2'd1,
    SType   = 2'd2,
    BType   = 2'd3
  } immSrc;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef struct packed {
    immSrc ImmSrc;
    logic  UsesImm;
    logic  Illegal;
  } decodeInfo;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } decodeState;

endpackage

// File: rtl/decode_stage_controller_instr_class_decoder.sv
// instr_class_decoder: purely combinational classification of one instruction.
//   instr - raw instruction word (WORD_SIZE bits, RV32 field layout)
//   info  - immediate format, immediate usage and illegal-encoding flag
// Shared with the future hazard unit, so it carries no state.
module instr_class_decoder
  import HighLevelControl::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] instr,
  output decodeInfo            info
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       unused_bits_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  // Register/immediate fields are irrelevant to classification.
  assign unused_bits_s = ^{instr[24:15], instr[11:7]};

  // Classify the opcode/funct fields; any illegal result forces the neutral immediate encoding.
  always_comb begin
    info.ImmSrc  = Imm11t0;
    info.UsesImm = 1'b0;
    info.Illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (opcode_s)
        OPC_OPIMM: begin
          if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
            // Shifts: only the 5-bit shamt is an immediate; funct7 selects logical/arith.
            info.ImmSrc  = Imm4t0;
            info.UsesImm = 1'b1;
            info.Illegal = !((funct7_s == 7'b0000000) ||
                             ((funct7_s == 7'b0100000) && (funct3_s == 3'b101)));
          end else begin
            info.ImmSrc  = Imm11t0;
            info.UsesImm = 1'b1;
            info.Illegal = 1'b0;
          end
        end
        OPC_LOAD, OPC_JALR: begin
          info.ImmSrc  = Imm11t0;
          info.UsesImm = 1'b1;
          info.Illegal = 1'b0;
        end
        OPC_STORE: begin
          if (funct3_s <= 3'b010) begin
            info.ImmSrc  = SType;
            info.UsesImm = 1'b1;
            info.Illegal = 1'b0;
          end else begin
            info.Illegal = 1'b1;
          end
        end
        OPC_OP: begin
          info.ImmSrc  = Imm11t0;
          info.UsesImm = 1'b0;
          info.Illegal = 1'b0;
        end
        default: begin
          info.Illegal = 1'b1;
        end
      endcase
    end else begin
      info.Illegal = 1'b1;
    end
    if (info.Illegal) begin
      info.ImmSrc  = Imm11t0;
      info.UsesImm = 1'b0;
    end else begin
      info.ImmSrc  = info.ImmSrc;
    end
  end

endmodule

// File: rtl/decode_stage_controller.sv
// decode_stage_controller: decode-stage sequencer between fetch and execute.
// A 2-entry skid queue (head/tail pointers + count) buffers fetched words together
// with their classification; a RUN/HALT FSM stops intake once an illegal
// instruction reaches execute until Flush.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   InValid/InReady/Instr   - fetch-side handshake and instruction
//   Flush                   - drop all buffered entries, return to RUN
//   OutValid/OutReady       - execute-side handshake
//   OutInstr/ImmSrc/UsesImm/Illegal - head entry and its classification
//   Halted                  - FSM is in HALT
//   IllegalCnt              - illegal deliveries (saturating)
// Build option: define DECODE_ILLEGAL_COUNT_EN to implement IllegalCnt;
// otherwise it is tied to zero.
// All outputs are registered: they are loaded from the next-state head entry.
module decode_stage_controller
  import HighLevelControl::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [WORD_SIZE-1:0] Instr,
  input  logic                 Flush,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [WORD_SIZE-1:0] OutInstr,
  output immSrc                ImmSrc,
  output logic                 UsesImm,
  output logic                 Illegal,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] IllegalCnt
);

  logic [WORD_SIZE-1:0] instr_q_r   [2];
  decodeInfo            info_q_r    [2];
  logic [WORD_SIZE-1:0] instr_nxt_s [2];
  decodeInfo            info_nxt_s  [2];
  logic                 head_r, tail_r, head_nxt_s, tail_nxt_s;
  logic [1:0]           count_r, count_nxt_s;
  decodeState           state_r, state_nxt_s;

  logic                 in_ready_r, out_valid_r, out_uses_imm_r, out_illegal_r, halted_r;
  logic [WORD_SIZE-1:0] out_instr_r;
  immSrc                out_imm_src_r;

  decodeInfo            dec_info_s;
  logic                 accept_s, deliver_s;

  instr_class_decoder #(.WORD_SIZE(WORD_SIZE)) u_decoder (
    .instr (Instr),
    .info  (dec_info_s)
  );

  assign accept_s  = InValid & in_ready_r;
  assign deliver_s = out_valid_r & OutReady;

  // Next queue/FSM state; flush wins over accept and FSM updates.
  always_comb begin
    instr_nxt_s = instr_q_r;
    info_nxt_s  = info_q_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    state_nxt_s = state_r;
    if (Flush) begin
      head_nxt_s  = 1'b0;
      tail_nxt_s  = 1'b0;
      count_nxt_s = 2'd0;
      state_nxt_s = RUN;
    end else begin
      if (accept_s) begin
        instr_nxt_s[tail_r] = Instr;
        info_nxt_s[tail_r]  = dec_info_s;
        tail_nxt_s          = ~tail_r;
      end else begin
        tail_nxt_s = tail_r;
      end
      if (deliver_s) begin
        head_nxt_s = ~head_r;
      end else begin
        head_nxt_s = head_r;
      end
      case ({accept_s, deliver_s})
        2'b10:   count_nxt_s = count_r + 2'd1;
        2'b01:   count_nxt_s = count_r - 2'd1;
        default: count_nxt_s = count_r;
      endcase
      if (deliver_s && out_illegal_r) begin
        state_nxt_s = HALT;
      end else begin
        state_nxt_s = state_r;
      end
    end
  end

  // Queue/FSM state and registered outputs, loaded from the next head entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_q_r[0]   <= {WORD_SIZE{1'b0}};
      instr_q_r[1]   <= {WORD_SIZE{1'b0}};
      info_q_r[0]    <= '{ImmSrc: Imm11t0, UsesImm: 1'b0, Illegal: 1'b0};
      info_q_r[1]    <= '{ImmSrc: Imm11t0, UsesImm: 1'b0, Illegal: 1'b0};
      head_r         <= 1'b0;
      tail_r         <= 1'b0;
      count_r        <= 2'd0;
      state_r        <= RUN;
      in_ready_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      out_instr_r    <= {WORD_SIZE{1'b0}};
      out_imm_src_r  <= Imm11t0;
      out_uses_imm_r <= 1'b0;
      out_illegal_r  <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      instr_q_r      <= instr_nxt_s;
      info_q_r       <= info_nxt_s;
      head_r         <= head_nxt_s;
      tail_r         <= tail_nxt_s;
      count_r        <= count_nxt_s;
      state_r        <= state_nxt_s;
      in_ready_r     <= (state_nxt_s == RUN) && (count_nxt_s != 2'd2);
      halted_r       <= (state_nxt_s == HALT);
      out_valid_r    <= (count_nxt_s != 2'd0);
      if (count_nxt_s != 2'd0) begin
        out_instr_r    <= instr_nxt_s[head_nxt_s];
        out_imm_src_r  <= info_nxt_s[head_nxt_s].ImmSrc;
        out_uses_imm_r <= info_nxt_s[head_nxt_s].UsesImm;
        out_illegal_r  <= info_nxt_s[head_nxt_s].Illegal;
      end else begin
        out_instr_r    <= {WORD_SIZE{1'b0}};
        out_imm_src_r  <= Imm11t0;
        out_uses_imm_r <= 1'b0;
        out_illegal_r  <= 1'b0;
      end
    end
  end

`ifdef DECODE_ILLEGAL_COUNT_EN
  logic [CNT_WIDTH-1:0] illegal_cnt_r;

  // Saturating count of illegal instructions handed to execute (flush does not clear it).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      illegal_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (deliver_s && out_illegal_r && (illegal_cnt_r != {CNT_WIDTH{1'b1}})) begin
      illegal_cnt_r <= illegal_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

  assign IllegalCnt = illegal_cnt_r;
`else
  assign IllegalCnt = {CNT_WIDTH{1'b0}};
`endif

  assign InReady  = in_ready_r;
  assign OutValid = out_valid_r;
  assign OutInstr = out_instr_r;
  assign ImmSrc   = out_imm_src_r;
  assign UsesImm  = out_uses_imm_r;
  assign Illegal  = out_illegal_r;
  assign Halted   = halted_r;

endmodule

// File: tb/tb_decode_stage_controller.sv
// Self-checking bench for decode_stage_controller: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_decode_stage_controller;
  import HighLevelControl::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          InValid = 1'b0, OutReady = 1'b0, Flush = 1'b0;
  logic [31:0]   Instr = 32'd0;
  logic          InReady, OutValid, UsesImm, Illegal, Halted;
  logic [31:0]   OutInstr;
  immSrc         ImmSrc;
  logic [CW-1:0] IllegalCnt;

  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;

  logic [31:0]   mq[$];
  bit            m_halt = 1'b0;
  bit            exp_in_ready = 1'b0;
  int unsigned   exp_cnt = 0;

  decode_stage_controller #(.WORD_SIZE(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady), .Instr(Instr),
    .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr),
    .ImmSrc(ImmSrc), .UsesImm(UsesImm), .Illegal(Illegal), .Halted(Halted),
    .IllegalCnt(IllegalCnt)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference classification written from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] w, output logic [1:0] imm,
                                     output logic uses, output logic ill);
    logic is_shift, shift_ok;
    imm = 2'd0; uses = 1'b0; ill = 1'b1;
    is_shift = (w[6:0] == 7'h13) && (w[13:12] == 2'b01);
    shift_ok = (w[31:25] == 7'h00) || ((w[31:25] == 7'h20) && w[14]);
    if (w[1:0] == 2'b11) begin
      if (is_shift) begin
        if (shift_ok) begin imm = 2'd1; uses = 1'b1; ill = 1'b0; end
      end else if (w[6:0] == 7'h13 || w[6:0] == 7'h03 || w[6:0] == 7'h67) begin
        imm = 2'd0; uses = 1'b1; ill = 1'b0;
      end else if (w[6:0] == 7'h23 && w[14:12] < 3'd3) begin
        imm = 2'd2; uses = 1'b1; ill = 1'b0;
      end else if (w[6:0] == 7'h33) begin
        ill = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[6:0] = 7'h13;
      1: begin w[6:0] = 7'h13; w[13:12] = 2'b01;
               w[31:25] = ($urandom_range(0, 3) == 0) ? w[31:25] : ($urandom_range(0, 1) ? 7'h20 : 7'h00); end
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h33;
      default: w = w;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    logic [1:0] im; logic us, il;
    check_value("in_ready", {31'd0, InReady}, {31'd0, exp_in_ready});
    check_value("out_valid", {31'd0, OutValid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    check_value("halted", {31'd0, Halted}, {31'd0, m_halt});
    check_value("illegal_cnt", {{(32-CW){1'b0}}, IllegalCnt}, exp_cnt);
    if (mq.size() > 0) begin
      ref_decode(mq[0], im, us, il);
      check_value("out_instr", OutInstr, mq[0]);
      check_value("imm_src", {30'd0, ImmSrc}, {30'd0, im});
      check_value("uses_imm", {31'd0, UsesImm}, {31'd0, us});
      check_value("illegal", {31'd0, Illegal}, {31'd0, il});
    end
  endtask

  // One clock: drive inputs, predict the edge, then compare after it.
  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl);
    logic acc, dlv; logic [1:0] im; logic us, il;
    InValid = iv; Instr = ins; OutReady = ordy; Flush = fl;
    acc = iv && exp_in_ready;
    dlv = (mq.size() > 0) && ordy;
    @(posedge clk); #1;
    if (dlv) begin
      ref_decode(mq[0], im, us, il);
      void'(mq.pop_front());
      if (il) begin
        m_halt = 1'b1;
`ifdef DECODE_ILLEGAL_COUNT_EN
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
      end
    end
    if (acc) mq.push_back(ins);
    if (fl) begin mq.delete(); m_halt = 1'b0; end
    exp_in_ready = !m_halt && (mq.size() < 2);
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0; Instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_halt = 1'b0; exp_in_ready = 1'b0; exp_cnt = 0;
    check_value("rst_out_instr", OutInstr, 32'd0);
    check_value("rst_imm_src", {30'd0, ImmSrc}, 32'd0);
    check_value("rst_uses_imm", {31'd0, UsesImm}, 32'd0);
    check_value("rst_illegal", {31'd0, Illegal}, 32'd0);
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    // Single addi with immediate consumption by execute.
    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    check_value("addi_imm", {30'd0, ImmSrc}, {30'd0, Imm11t0});
    check_value("addi_uses", {31'd0, UsesImm}, 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    // Fill the skid queue while execute stalls, then drain in order.
    step(1'b1, 32'h00209023, 1'b0, 1'b0);
    step(1'b1, 32'h40305093, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 1'b0, 1'b0);
    check_value("full_in_ready", {31'd0, InReady}, 32'd0);
    check_value("full_head_stype", {30'd0, ImmSrc}, {30'd0, SType});
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check_value("drain_imm4", {30'd0, ImmSrc}, {30'd0, Imm4t0});
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    // Illegal word ahead of a legal one: halt after delivery, tail still drains.
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check_value("halt_after_illegal", {31'd0, Halted}, 32'd1);
    step(1'b1, 32'h00000013, 1'b1, 1'b0);
    step(1'b1, 32'h00000013, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_COUNT_EN
    check_value("cnt_one_illegal", {{(32-CW){1'b0}}, IllegalCnt}, 32'd1);
`else
    check_value("cnt_tied_zero", {{(32-CW){1'b0}}, IllegalCnt}, 32'd0);
`endif
    step(1'b0, 32'd0, 1'b0, 1'b1);
    check_value("flush_release", {31'd0, Halted}, 32'd0);
    // Full queue flushed while fetch still presents a word.
    step(1'b1, 32'h00500093, 1'b0, 1'b0);
    step(1'b1, 32'h00000033, 1'b0, 1'b0);
    step(1'b1, 32'h00100013, 1'b0, 1'b1);
    check_value("flush_empty", {31'd0, OutValid}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // Steady stream through a one-entry queue.
    step(1'b1, rand_instr() | 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, {$urandom_range(0, 1) ? 7'h00 : 7'h01, 25'h0000013}, 1'b1, 1'b0);
      check_value("stream_in_ready", {31'd0, InReady}, 32'd1);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    // Randomized traffic with occasional flushes and mid-transfer resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6,
             $urandom_range(0, 99) < 3);
      end
    end
`ifdef DECODE_ILLEGAL_COUNT_EN
    do_reset();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b1);
    end
    check_value("cnt_saturated", {{(32-CW){1'b0}}, IllegalCnt}, (32'd1 << CW) - 32'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
